// File: rtl/pacman_pkg.sv
// Shared types and widths for the ghost movement logic.
package pacman_pkg;

    localparam int XW = 10;
    localparam int YW = 9;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_RIGHT = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        HOME   = 2'd0,
        ROAM   = 2'd1,
        FRIGHT = 2'd2,
        EATEN  = 2'd3
    } ghost_state_t;

    // Larger of two sizes, used to size shared counters.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ghost_step_timer.sv
// Tick-driven movement-rate divider. Counts frame ticks while enabled and
// fires step_now on the tick that completes one period of the selected rate.
module ghost_step_timer
    import pacman_pkg::*;
#(
    parameter int ROAM_DIV   = 4,
    parameter int FRIGHT_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    input  logic fright_rate,
    output logic step_now
);
    localparam int DW = $clog2(max2(ROAM_DIV, FRIGHT_DIV) + 1);

    logic [DW-1:0] cnt;
    logic [DW-1:0] last;

    assign last     = fright_rate ? DW'(FRIGHT_DIV - 1) : DW'(ROAM_DIV - 1);
    assign step_now = enable && tick && (cnt == last);

    // Divider count: wraps to zero on the step tick, cleared on mode changes.
    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (enable && tick)
            cnt <= step_now ? '0 : cnt + DW'(1);
    end

endmodule

// File: rtl/ghost_mover.sv
// ghost_mover: one ghost's tile position, heading, movement rate and
// behaviour mode, plus collision events against Pac-Man.
// Build option GHOST_WRAP_EN: when defined, moving off a board edge wraps to
// the opposite edge; when undefined, a board edge acts as a wall.
module ghost_mover
    import pacman_pkg::*;
#(
    parameter int WIDTH        = 96,
    parameter int HEIGHT       = 72,
    parameter int X_START      = 46,
    parameter int Y_START      = 28,
    parameter int ROAM_DIV     = 4,
    parameter int FRIGHT_DIV   = 8,
    parameter int FRIGHT_TICKS = 600,
    parameter int HOME_TICKS   = 120
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          e_start,
    input  logic          tick,
    input  logic [1:0]    dir_req,
    input  logic [3:0]    blocked,
    input  logic          power,
    input  logic [XW-1:0] xPac,
    input  logic [YW-1:0] yPac,
    output logic [XW-1:0] xGhost,
    output logic [YW-1:0] yGhost,
    output logic [1:0]    dir_cur,
    output logic          frightened,
    output logic          collide_kill,
    output logic          collide_eaten,
    output logic          step
);
    localparam int TW = $clog2(max2(HOME_TICKS, FRIGHT_TICKS) + 1);

    ghost_state_t  state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    dir_t          dir_q, move_dir;
    logic          restart;
    logic          overlap, overlap_q, rise;
    logic          div_clear, go_home, kill_nxt, eaten_nxt;
    logic          step_now, can_move, do_move;
    logic [3:0]    edge_blk, eff_blk;
    logic [XW-1:0] x_mv;
    logic [YW-1:0] y_mv;

    assign restart    = reset | e_start;
    assign overlap    = (xGhost == xPac) && (yGhost == yPac);
    assign rise       = overlap & ~overlap_q;
    assign frightened = (state == FRIGHT);
    assign dir_cur    = dir_q;

`ifdef GHOST_WRAP_EN
    assign edge_blk = 4'b0000;
`else
    // Bit index follows dir_t: {LEFT, RIGHT, DOWN, UP}.
    assign edge_blk = {xGhost == XW'(1), xGhost == XW'(WIDTH),
                       yGhost == YW'(HEIGHT), yGhost == YW'(1)};
`endif
    assign eff_blk = blocked | edge_blk;

    // Mode register.
    always_ff @(posedge clk) begin
        if (restart)
            state <= HOME;
        else
            state <= state_nxt;
    end

    // Mode transitions and timer. Collision beats power, power beats expiry;
    // any mode change also clears the divider and suppresses this tick's step.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        div_clear = 1'b0;
        go_home   = 1'b0;
        kill_nxt  = 1'b0;
        eaten_nxt = 1'b0;
        if (tick && state != ROAM)
            timer_nxt = timer + TW'(1);
        case (state)
            HOME, EATEN: begin
                if (tick && timer == TW'(HOME_TICKS - 1)) begin
                    state_nxt = ROAM;
                    timer_nxt = '0;
                    div_clear = 1'b1;
                end
            end
            ROAM: begin
                kill_nxt = rise;
                if (power) begin
                    state_nxt = FRIGHT;
                    timer_nxt = '0;
                    div_clear = 1'b1;
                end
            end
            FRIGHT: begin
                if (rise) begin
                    state_nxt = EATEN;
                    eaten_nxt = 1'b1;
                    go_home   = 1'b1;
                    timer_nxt = '0;
                    div_clear = 1'b1;
                end else if (power) begin
                    timer_nxt = '0;
                end else if (tick && timer == TW'(FRIGHT_TICKS - 1)) begin
                    state_nxt = ROAM;
                    timer_nxt = '0;
                    div_clear = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Heading choice: requested direction first, else keep going, else stay.
    always_comb begin
        move_dir = dir_q;
        can_move = 1'b0;
        if (!eff_blk[dir_req]) begin
            move_dir = dir_t'(dir_req);
            can_move = 1'b1;
        end else if (!eff_blk[dir_q]) begin
            can_move = 1'b1;
        end
    end

    // Neighbour tile along move_dir, wrapping so the result stays on-board.
    always_comb begin
        x_mv = xGhost;
        y_mv = yGhost;
        case (move_dir)
            DIR_UP:    y_mv = (yGhost == YW'(1))      ? YW'(HEIGHT) : yGhost - YW'(1);
            DIR_DOWN:  y_mv = (yGhost == YW'(HEIGHT)) ? YW'(1)      : yGhost + YW'(1);
            DIR_RIGHT: x_mv = (xGhost == XW'(WIDTH))  ? XW'(1)      : xGhost + XW'(1);
            DIR_LEFT:  x_mv = (xGhost == XW'(1))      ? XW'(WIDTH)  : xGhost - XW'(1);
            default: ;
        endcase
    end

    ghost_step_timer #(
        .ROAM_DIV   (ROAM_DIV),
        .FRIGHT_DIV (FRIGHT_DIV)
    ) u_step_timer (
        .clk         (clk),
        .reset       (restart),
        .clear       (div_clear),
        .enable      (state == ROAM || state == FRIGHT),
        .tick        (tick),
        .fright_rate (state == FRIGHT),
        .step_now    (step_now)
    );

    assign do_move = step_now & can_move & ~div_clear;

    // Position, heading, timer and registered event pulses.
    always_ff @(posedge clk) begin
        if (restart) begin
            xGhost        <= XW'(X_START);
            yGhost        <= YW'(Y_START);
            dir_q         <= DIR_LEFT;
            timer         <= '0;
            overlap_q     <= 1'b0;
            collide_kill  <= 1'b0;
            collide_eaten <= 1'b0;
            step          <= 1'b0;
        end else begin
            timer         <= timer_nxt;
            overlap_q     <= overlap;
            collide_kill  <= kill_nxt;
            collide_eaten <= eaten_nxt;
            step          <= do_move;
            if (go_home) begin
                xGhost <= XW'(X_START);
                yGhost <= YW'(Y_START);
                dir_q  <= DIR_LEFT;
            end else if (do_move) begin
                xGhost <= x_mv;
                yGhost <= y_mv;
                dir_q  <= move_dir;
            end
        end
    end

endmodule

// File: tb/tb_ghost_mover.sv
// Self-checking bench for ghost_mover: a cycle model feeds a scoreboard of
// expected outputs, plus directed checks on the key scenarios.
module tb_ghost_mover;
    import pacman_pkg::*;

    localparam int WIDTH = 96, HEIGHT = 72, X_START = 46, Y_START = 28;
    localparam int ROAM_DIV = 4, FRIGHT_DIV = 8;
    localparam int FRIGHT_TICKS = 600, HOME_TICKS = 120;

    logic       clk = 1'b0;
    logic       reset, e_start, tick, power;
    logic [1:0] dir_req;
    logic [3:0] blocked;
    logic [9:0] xPac;
    logic [8:0] yPac;
    logic [9:0] xGhost;
    logic [8:0] yGhost;
    logic [1:0] dir_cur;
    logic       frightened, collide_kill, collide_eaten, step;

    ghost_mover #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .X_START(X_START), .Y_START(Y_START),
        .ROAM_DIV(ROAM_DIV), .FRIGHT_DIV(FRIGHT_DIV),
        .FRIGHT_TICKS(FRIGHT_TICKS), .HOME_TICKS(HOME_TICKS)
    ) dut (
        .clk(clk), .reset(reset), .e_start(e_start), .tick(tick),
        .dir_req(dir_req), .blocked(blocked), .power(power),
        .xPac(xPac), .yPac(yPac), .xGhost(xGhost), .yGhost(yGhost),
        .dir_cur(dir_cur), .frightened(frightened),
        .collide_kill(collide_kill), .collide_eaten(collide_eaten), .step(step)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    int           m_x, m_y, m_dir, m_tmr, m_div;
    ghost_state_t m_st;
    bit           m_ovq, m_kill, m_eat, m_step;
    logic [24:0]  exp_q[$];

    function automatic bit legal(input int d, output int nx, output int ny);
        nx = m_x;
        ny = m_y;
        case (d)
            0: ny = ny - 1;
            1: ny = ny + 1;
            2: nx = nx + 1;
            default: nx = nx - 1;
        endcase
        if (blocked[d]) return 1'b0;
`ifdef GHOST_WRAP_EN
        if (nx < 1) nx = WIDTH; else if (nx > WIDTH) nx = 1;
        if (ny < 1) ny = HEIGHT; else if (ny > HEIGHT) ny = 1;
        return 1'b1;
`else
        return (nx >= 1 && nx <= WIDTH && ny >= 1 && ny <= HEIGHT);
`endif
    endfunction

    always @(posedge clk) begin : model
        int  nx, ny, lim, dv;
        bit  ov, rise, chg;
        if (reset || e_start) begin
            m_x = X_START; m_y = Y_START; m_dir = 3; m_st = HOME;
            m_tmr = 0; m_div = 0; m_ovq = 0; m_kill = 0; m_eat = 0; m_step = 0;
        end else begin
            ov    = (m_x == int'(xPac)) && (m_y == int'(yPac));
            rise  = ov && !m_ovq;
            m_ovq = ov;
            m_kill = 0; m_eat = 0; m_step = 0; chg = 0;
            if (m_st == FRIGHT && rise) begin
                m_eat = 1; m_st = EATEN; m_x = X_START; m_y = Y_START; m_dir = 3;
                m_tmr = 0; m_div = 0;
            end else begin
                if (m_st == ROAM && rise) m_kill = 1;
                if (power && m_st == ROAM) begin
                    m_st = FRIGHT; m_tmr = 0; m_div = 0; chg = 1;
                end else if (power && m_st == FRIGHT) begin
                    m_tmr = 0;
                end else if (tick && m_st != ROAM) begin
                    lim = (m_st == FRIGHT) ? FRIGHT_TICKS : HOME_TICKS;
                    if (m_tmr == lim - 1) begin
                        m_st = ROAM; m_tmr = 0; m_div = 0; chg = 1;
                    end else m_tmr++;
                end
                if (!chg && tick && (m_st == ROAM || m_st == FRIGHT)) begin
                    dv = (m_st == FRIGHT) ? FRIGHT_DIV : ROAM_DIV;
                    if (m_div == dv - 1) begin
                        m_div = 0;
                        if (legal(int'(dir_req), nx, ny)) begin
                            m_x = nx; m_y = ny; m_dir = int'(dir_req); m_step = 1;
                        end else if (legal(m_dir, nx, ny)) begin
                            m_x = nx; m_y = ny; m_step = 1;
                        end
                    end else m_div++;
                end
            end
        end
        exp_q.push_back({10'(m_x), 9'(m_y), 2'(m_dir), m_st == FRIGHT, m_kill, m_eat, m_step});
    end

    // Scoreboard: compare every cycle's outputs away from the active edge.
    always @(negedge clk) begin
        logic [24:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cycle", 32'({xGhost, yGhost, dir_cur, frightened, collide_kill, collide_eaten, step}),
                32'(e));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic tick1();
        tick = 1'b1; cyc(); tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin tick1(); cyc(); end
    endtask

    initial begin
        reset = 1; e_start = 0; tick = 0; power = 0;
        dir_req = 2'd3; blocked = 4'h0; xPac = 10'd90; yPac = 9'd70;
        cyc(3);
        reset = 0;
        chk("rst_x", 32'(xGhost), 46);
        chk("rst_y", 32'(yGhost), 28);
        chk("rst_dir", 32'(dir_cur), 3);
        chk("rst_fright", 32'(frightened), 0);
        chk("rst_step", 32'(step), 0);

        // Home hold, then first ROAM step on the fourth tick.
        ticks(120);
        chk("home_x", 32'(xGhost), 46);
        ticks(3);
        chk("pre_step_x", 32'(xGhost), 46);
        tick1();
        chk("first_step_x", 32'(xGhost), 45);
        chk("first_step_pulse", 32'(step), 1);
        cyc();
        chk("step_one_cycle", 32'(step), 0);

        // Fallback to current heading, then fully walled in.
        dir_req = 2'd2; ticks(4);
        chk("turn_right_x", 32'(xGhost), 46);
        dir_req = 2'd0; blocked = 4'b0001; ticks(4);
        chk("fallback_x", 32'(xGhost), 47);
        chk("fallback_dir", 32'(dir_cur), 2);
        blocked = 4'hF; ticks(3); tick1();
        chk("walled_step", 32'(step), 0);
        chk("walled_x", 32'(xGhost), 47);
        cyc();

        // Travel to (1,10) and try to leave across the left edge.
        blocked = 4'h0; dir_req = 2'd3; ticks(46 * 4);
        dir_req = 2'd0; ticks(18 * 4);
        chk("corner_x", 32'(xGhost), 1);
        chk("corner_y", 32'(yGhost), 10);
        blocked = 4'b0001; dir_req = 2'd3; ticks(3); tick1();
`ifdef GHOST_WRAP_EN
        chk("edge_x", 32'(xGhost), 96);
        chk("edge_step", 32'(step), 1);
        chk("edge_dir", 32'(dir_cur), 3);
`else
        chk("edge_x", 32'(xGhost), 1);
        chk("edge_step", 32'(step), 0);
        chk("edge_dir", 32'(dir_cur), 0);
`endif
        chk("edge_y", 32'(yGhost), 10);
        cyc();

        // Restart, kill collision, fright rate, restart mid-fright.
        e_start = 1; cyc(); e_start = 0;
        chk("estart_x", 32'(xGhost), 46);
        chk("estart_dir", 32'(dir_cur), 3);
        blocked = 4'h0; dir_req = 2'd3;
        power = 1; cyc(); power = 0;
        chk("home_power", 32'(frightened), 0);
        ticks(120);
        xPac = 10'd46; yPac = 9'd28; cyc();
        chk("kill_pulse", 32'(collide_kill), 1);
        cyc();
        chk("kill_one_cycle", 32'(collide_kill), 0);
        cyc(2);
        chk("kill_no_repeat", 32'(collide_kill), 0);
        xPac = 10'd90; yPac = 9'd70;
        power = 1; cyc(); power = 0;
        chk("fright_on", 32'(frightened), 1);
        ticks(7);
        chk("fright_wait_x", 32'(xGhost), 46);
        tick1();
        chk("fright_step_x", 32'(xGhost), 45);
        chk("fright_step_pulse", 32'(step), 1);
        cyc();
        e_start = 1; cyc(); e_start = 0;
        chk("midfright_x", 32'(xGhost), 46);
        chk("midfright_fright", 32'(frightened), 0);

        // Fright extended by a second pellet.
        ticks(120);
        power = 1; cyc(); power = 0;
        ticks(500);
        chk("fright_500", 32'(frightened), 1);
        power = 1; cyc(); power = 0;
        ticks(599);
        chk("fright_1099", 32'(frightened), 1);
        ticks(1);
        chk("fright_end", 32'(frightened), 0);

        // Eaten beats a coincident pellet; respawn after the home hold.
        power = 1; cyc(); power = 0;
        xPac = 10'(m_x); yPac = 9'(m_y); power = 1; cyc(); power = 0;
        chk("eaten_pulse", 32'(collide_eaten), 1);
        chk("eaten_x", 32'(xGhost), 46);
        chk("eaten_y", 32'(yGhost), 28);
        chk("eaten_fright", 32'(frightened), 0);
        cyc();
        chk("eaten_one_cycle", 32'(collide_eaten), 0);
        xPac = 10'd90; yPac = 9'd70;
        power = 1; cyc(); power = 0;
        chk("eaten_power", 32'(frightened), 0);
        ticks(119);
        chk("eaten_hold_x", 32'(xGhost), 46);
        ticks(4); tick1();
        chk("respawn_step_x", 32'(xGhost), 45);
        cyc();

        // Random mix, checked by the scoreboard.
        for (int i = 0; i < 600; i++) begin
            tick    = ($urandom_range(0, 2) == 0);
            dir_req = 2'($urandom);
            blocked = 4'($urandom) & 4'($urandom);
            power   = ($urandom_range(0, 60) == 0);
            e_start = ($urandom_range(0, 400) == 0);
            if ($urandom_range(0, 40) == 0) begin
                xPac = 10'(m_x); yPac = 9'(m_y);
            end else if ($urandom_range(0, 3) == 0) begin
                xPac = 10'd90; yPac = 9'd70;
            end
            cyc();
        end
        tick = 0; power = 0; e_start = 0;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ghost_mover.md
Name: ghost_mover

Overview:
Parametrised successor to the single-ghost position register.
- Owns one ghost's tile position, current heading, movement-rate divider and behaviour mode (home / roam / frightened / eaten).
- Consumes per-direction wall flags from the maze lookup, a frame tick from the timing block, a power-pellet pulse and Pac-Man's position.
- Produces the ghost position and collision events for game control. One instance per ghost.

Parameters:
WIDTH, 96, board width in tiles; valid x is 1..WIDTH
HEIGHT, 72, board height in tiles; valid y is 1..HEIGHT
X_START, 46, home tile x
Y_START, 28, home tile y
ROAM_DIV, 4, ticks per step in ROAM (>=1)
FRIGHT_DIV, 8, ticks per step in FRIGHT (>=1)
FRIGHT_TICKS, 600, ticks spent in FRIGHT
HOME_TICKS, 120, ticks held at home before release

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
e_start  in  1  synchronous restart to home, same effect as reset
tick  in  1  one-cycle frame tick
dir_req  in  2  requested heading (dir_t)
blocked  in  4  wall flags at current tile, bit index = dir_t
power  in  1  one-cycle power-pellet pulse
xPac  in  10  Pac-Man x
yPac  in  9  Pac-Man y
xGhost  out  10  ghost x
yGhost  out  9  ghost y
dir_cur  out  2  current heading
frightened  out  1  high in FRIGHT
collide_kill  out  1  one-cycle pulse: ghost caught Pac-Man
collide_eaten  out  1  one-cycle pulse: Pac-Man ate ghost
step  out  1  one-cycle pulse on the cycle the position updates

Behaviour:
- Reset / e_start:
  - Outputs: xGhost=X_START, yGhost=Y_START, dir_cur=DIR_LEFT, state=HOME.
  - Divider and mode timer cleared; all pulses 0; overlap_q=0.
  - Reset takes effect mid-step and overrides every other event.
- Mode timer counts ticks only.
- HOME: no movement. After HOME_TICKS ticks -> ROAM, timer cleared.
- ROAM: moves once every ROAM_DIV ticks.
  - power -> FRIGHT; timer and divider cleared.
- FRIGHT: moves once every FRIGHT_DIV ticks; frightened=1.
  - power restarts timer at 0.
  - After FRIGHT_TICKS ticks -> ROAM.
- EATEN: position forced to home in the transition cycle, dir_cur=DIR_LEFT. After HOME_TICKS ticks -> ROAM.
- Step rule: on the tick the divider hits DIV-1, the divider clears and in the same edge:
  - If dir_req is not blocked: heading=dir_req, move one tile that way.
  - Else if dir_cur is not blocked: move one tile along dir_cur.
  - Else: stay, and step is not pulsed.
  - Exactly one axis changes by exactly 1. UP decrements y; RIGHT increments x.
- Wrap: x=1 moving LEFT -> WIDTH; x=WIDTH moving RIGHT -> 1; same rule on y with HEIGHT. Coordinates never leave 1..WIDTH / 1..HEIGHT, including transiently.
- Collision:
  - overlap = (xGhost==xPac && yGhost==yPac), computed from registered outputs; overlap_q registered.
  - A rising overlap in ROAM pulses collide_kill for one cycle.
  - A rising overlap in FRIGHT pulses collide_eaten and enters EATEN on the same edge.
  - No pulses in HOME or EATEN.
  - Pulses are registered: one cycle after the overlapping position is visible.
- Same-cycle priority: reset/e_start > collision > power > timer expiry > step. Examples:
  - power together with a FRIGHT collision: eaten wins.
  - power in HOME or EATEN: ignored.
- Arithmetic: divider and timer widths from $clog2(max+1); position math in XW/YW bits with no overflow.

Optional Feature:
- Macro: GHOST_WRAP_EN.
- Defined: edge wrap exactly as above.
- Undefined: no wrap. A move across a board edge is treated as blocked for that direction; the fallback then follows the normal step rule.

Decomposition:
- Package pacman_pkg:
  - dir_t enum: DIR_UP=0, DIR_DOWN=1, DIR_RIGHT=2, DIR_LEFT=3.
  - ghost_state_t: HOME, ROAM, FRIGHT, EATEN.
  - XW=10, YW=9 localparams.
- Sub-module ghost_step_timer: tick-driven divider with selectable divisor (ROAM_DIV/FRIGHT_DIV), clear input, step_now output.

Test Plan:
1. Reset, 120 ticks, no walls, dir_req=LEFT -> position stays (46,28) for 120 ticks; first step on 4th tick in ROAM to (45,28); step pulses.
2. Ghost at (1,10), dir_req=LEFT, one step -> (96,10). With GHOST_WRAP_EN undefined and blocked[DIR_LEFT]=0 -> stays (1,10), no step pulse.
3. dir_req=UP with blocked[UP]=1, dir_cur=RIGHT unblocked -> x+1, dir_cur stays RIGHT. All four blocked -> no move, no step pulse.
4. ROAM, Pac-Man moved onto ghost tile -> collide_kill high exactly 1 cycle; held overlap gives no repeat; e_start mid-FRIGHT -> (46,28), HOME, frightened=0 next cycle.
5. power in ROAM -> frightened=1, steps every 8 ticks. Second power at tick 500 -> FRIGHT lasts until tick 1100, then ROAM.
6. FRIGHT overlap coincident with power -> collide_eaten 1 cycle, state EATEN, position (46,28); ROAM after 120 ticks.
